// File: rtl/cmd_dispatch.sv
// Command dispatcher: takes one opcode byte from the UART receiver, hands the
// UART over to the matching handler slot until it reports done (or runs too
// long), and answers unknown opcodes with a single NAK byte.
module cmd_dispatch #(
  parameter logic [7:0]  OPC0     = 8'h01,
  parameter logic [7:0]  OPC1     = 8'h02,
  parameter logic [7:0]  OPC2     = 8'h03,
  parameter logic [7:0]  OPC3     = 8'h04,
  parameter logic [7:0]  NAK_BYTE = 8'h15,
  parameter logic [23:0] TIMEOUT  = 24'd1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_ready,
  input  logic [7:0]  rx_data,
  input  logic        tx_active,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic [3:0]  h_activate,
  input  logic [3:0]  h_done,
  input  logic [31:0] h_tx_data,
  input  logic [3:0]  h_tx_start,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    ACTIVE,
    RELEASE,
    NAK_WAIT,
    NAK_SEND,
    DRAIN
  } state_t;

  localparam logic [23:0] RUN_LAST = TIMEOUT - 24'd1;

  state_t      state;
  state_t      state_nx;
  logic        rx_ready_d;
  logic        rx_rise;
  logic [7:0]  opc;
  logic [1:0]  sel;
  logic [1:0]  sel_nx;
  logic [23:0] run_cnt;
  logic        err_inc;
  logic        hit;
  logic [1:0]  hit_idx;

  assign rx_rise = rx_ready & ~rx_ready_d;
  assign busy    = (state != IDLE);

  // Opcode lookup; the lowest matching slot wins when parameters collide
  always_comb begin
    hit     = 1'b1;
    hit_idx = 2'd0;
    if (opc == OPC0)      hit_idx = 2'd0;
    else if (opc == OPC1) hit_idx = 2'd1;
    else if (opc == OPC2) hit_idx = 2'd2;
    else if (opc == OPC3) hit_idx = 2'd3;
    else                  hit     = 1'b0;
  end

  // Next-state logic; done takes precedence over the run-time limit
  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    err_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (rx_rise) state_nx = DECODE;
      end
      DECODE: begin
        if (hit) begin
          sel_nx   = hit_idx;
          state_nx = ACTIVE;
        end else begin
          state_nx = NAK_WAIT;
          err_inc  = 1'b1;
        end
      end
      ACTIVE: begin
        if (h_done[sel]) begin
          state_nx = RELEASE;
        end else if (run_cnt == RUN_LAST) begin
          state_nx = RELEASE;
          err_inc  = 1'b1;
        end
      end
      RELEASE: begin
        if (!h_done[sel] && !rx_ready && !tx_active) state_nx = IDLE;
      end
      NAK_WAIT: begin
        if (!tx_active) state_nx = NAK_SEND;
      end
      NAK_SEND: begin
        state_nx = DRAIN;
      end
      DRAIN: begin
        if (!rx_ready && !tx_active) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Transmit mux: selected handler passes straight through, NAK is a one-cycle pulse
  always_comb begin
    tx_data  = 8'h00;
    tx_start = 1'b0;
    case (state)
      ACTIVE: begin
        tx_data  = h_tx_data[{sel, 3'b000} +: 8];
        tx_start = h_tx_start[sel];
      end
      NAK_SEND: begin
        tx_data  = NAK_BYTE;
        tx_start = 1'b1;
      end
      default: begin
        tx_data  = 8'h00;
        tx_start = 1'b0;
      end
    endcase
  end

  // State register and receive edge history; history resets high so a byte
  // already valid when reset releases is not taken as a new command
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rx_ready_d <= 1'b1;
    end else begin
      state      <= state_nx;
      rx_ready_d <= rx_ready;
    end
  end

  // Command capture and slot selection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opc <= 8'h00;
      sel <= 2'd0;
    end else begin
      if (state == IDLE && rx_rise) opc <= rx_data;
      sel <= sel_nx;
    end
  end

  // Registered one-hot activate, high exactly while the FSM sits in ACTIVE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_activate <= 4'b0000;
    end else if (state_nx == ACTIVE) begin
      h_activate <= 4'b0001 << sel_nx;
    end else begin
      h_activate <= 4'b0000;
    end
  end

  // Handler run counter, cleared on entry to ACTIVE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_cnt <= 24'd0;
    end else if (state == DECODE) begin
      run_cnt <= 24'd0;
    end else if (state == ACTIVE) begin
      run_cnt <= run_cnt + 24'd1;
    end
  end

  // Saturating error counter for NAKs and timeouts
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt <= 8'h00;
    end else if (err_inc && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'h01;
    end
  end

endmodule

// File: doc/cmd_dispatch.md
CMD_DISPATCH -- requirements
Module: cmd_dispatch

Interface
REQ-001 Parameters SHALL be, one per line:
 OPC0, 8'h01, opcode routed to handler slot 0
 OPC1, 8'h02, opcode routed to handler slot 1
 OPC2, 8'h03, opcode routed to handler slot 2
 OPC3, 8'h04, opcode routed to handler slot 3
 NAK_BYTE, 8'h15, byte sent for an unknown opcode
 TIMEOUT, 24'd1000000, maximum handler run time in clk cycles, 2 or more
REQ-002 Ports SHALL be, one per line:
 clk  in  1  single system clock, all logic on its rising edge
 reset  in  1  asynchronous, active-low reset
 rx_ready  in  1  UART receiver byte-valid level
 rx_data  in  8  UART received byte
 tx_active  in  1  UART transmitter busy
 tx_data  out  8  byte to UART transmitter
 tx_start  out  1  UART transmit request
 h_activate  out  4  per-slot handler activate
 h_done  in  4  per-slot handler done
 h_tx_data  in  32  handler tx bytes, slot i on bits [8i+7:8i]
 h_tx_start  in  4  per-slot handler transmit request
 busy  out  1  high whenever state is not IDLE
 err_cnt  out  8  saturating count of NAKs plus timeouts

Function
REQ-003 The block SHALL keep one registered flag rx_ready_d; rx_rise = rx_ready & ~rx_ready_d.
REQ-004 States SHALL be IDLE, DECODE, ACTIVE, RELEASE, NAK_WAIT, NAK_SEND, DRAIN.
REQ-005 IDLE: on rx_rise, latch rx_data into opc and go to DECODE the next cycle; otherwise remain.
REQ-006 DECODE: on opc==OPCi, set sel=i and go to ACTIVE; when several OPCi match, the lowest i SHALL win.
REQ-007 DECODE: when no OPCi matches, go to NAK_WAIT and increment err_cnt.
REQ-008 ACTIVE: h_activate[sel]=1 and all other bits 0; h_activate SHALL be registered, first high in the cycle after DECODE.
REQ-009 ACTIVE: tx_data = h_tx_data slot sel and tx_start = h_tx_start[sel], combinational pass-through with zero added latency.
REQ-010 ACTIVE: a 24-bit run counter SHALL clear on entry and increment every cycle.
REQ-011 ACTIVE: h_done[sel]==1 SHALL move to RELEASE the next cycle; run counter == TIMEOUT-1 without done SHALL move to RELEASE and increment err_cnt.
REQ-012 When h_done[sel] and the timeout occur in the same cycle, done SHALL win and err_cnt SHALL be unchanged.
REQ-013 RELEASE: h_activate=0; go to IDLE only when h_done[sel]==0, rx_ready==0 and tx_active==0.
REQ-014 NAK_WAIT: go to NAK_SEND when tx_active==0.
REQ-015 NAK_SEND: tx_data=NAK_BYTE and tx_start=1 for exactly one cycle, then go to DRAIN.
REQ-016 DRAIN: go to IDLE when rx_ready==0 and tx_active==0.
REQ-017 rx_rise outside IDLE SHALL be ignored; those bytes belong to the active handler.
REQ-018 Outside ACTIVE and NAK_SEND, tx_start and tx_data SHALL be 0.
REQ-019 h_done bits of non-selected slots and h_tx_start of non-selected slots SHALL be ignored.
REQ-020 err_cnt SHALL saturate at 8'hFF and never wrap.
REQ-021 busy SHALL be 1 in every state except IDLE.

Reset
REQ-022 reset low SHALL asynchronously force: state IDLE; h_activate, tx_data, tx_start, err_cnt, opc, sel and run counter 0; busy 0.
REQ-023 rx_ready_d SHALL reset to 1 so a byte held valid across reset release does not dispatch.
REQ-024 Reset asserted mid-ACTIVE SHALL drop h_activate immediately, with no NAK and no err_cnt change.

Verification
REQ-025 Opcode dispatch: rx byte 0x02, handler 1 sends 0x00..0x03 then done -> h_activate=4'b0010 for the run; tx carries 0x00..0x03; return to IDLE after done, rx_ready and tx_active are all low.
REQ-026 Unknown opcode: rx byte 0x7A -> exactly one tx_start with tx_data=0x15; err_cnt=1; no h_activate bit ever set.
REQ-027 Timeout: TIMEOUT=16, opcode 0x01, handler never asserts done -> h_activate[0] high for exactly 16 cycles; err_cnt increments by 1; block back in IDLE.
REQ-028 Done on the timeout cycle: TIMEOUT=16, h_done[0] rises on the 16th ACTIVE cycle -> err_cnt unchanged.
REQ-029 Saturation and reset: 260 unknown opcodes -> err_cnt=0xFF; then reset pulse mid-ACTIVE -> all outputs 0 in the same cycle.
REQ-030 Ignored bytes: rx bytes arriving while ACTIVE -> no re-dispatch; rx_ready held high through reset release -> no dispatch.
